// File: rtl/sipo_frame_ctrl.sv
// Frame-based serial-to-parallel packer: pulls a fixed number of bits per
// frame, packs them LSB-first into DATA_OUT_W-bit words, zero-pads the final
// partial word and flags it as last.
module sipo_frame_ctrl #(
  parameter int unsigned DATA_OUT_W  = 8,
  parameter int unsigned FRAME_LEN_W = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_frame_start,
  input  logic [FRAME_LEN_W-1:0] i_frame_len,
  input  logic                   i_bit,
  input  logic                   i_bit_valid,
  output logic                   o_bit_ready,
  output logic [DATA_OUT_W-1:0]  o_data,
  output logic                   o_data_valid,
  input  logic                   i_data_ready,
  output logic                   o_data_last,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int unsigned IDX_W = $clog2(DATA_OUT_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [FRAME_LEN_W-1:0] rem_cnt, rem_nxt;
  logic [IDX_W-1:0]       bit_idx, idx_nxt;
  logic [DATA_OUT_W-1:0]  shreg, shreg_nxt;
  logic                   err_nxt;
  logic                   bit_acc;
  logic                   word_acc;

  // o_bit_ready and o_data_valid are registered copies of the state decode
  assign bit_acc  = i_bit_valid & o_bit_ready;
  assign word_acc = o_data_valid & i_data_ready;

  // The shift register is itself a flop, so it drives the word output directly
  assign o_data = shreg;

  // Next-state, counter, packing and error decode
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_cnt;
    idx_nxt   = bit_idx;
    shreg_nxt = shreg;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (i_frame_start) begin
          if (i_frame_len != '0) begin
            state_nxt = COLLECT;
            rem_nxt   = i_frame_len;
            idx_nxt   = '0;
            shreg_nxt = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        if (i_bit_valid) begin
          err_nxt = 1'b1;
        end
      end
      COLLECT: begin
        if (i_frame_start) begin
          err_nxt = 1'b1;
        end
        if (bit_acc) begin
          shreg_nxt[bit_idx] = i_bit;
          rem_nxt            = rem_cnt - FRAME_LEN_W'(1);
          // Hold the index at the top slot so it only wraps via the reload
          if ((bit_idx == IDX_W'(DATA_OUT_W - 1)) || (rem_cnt == FRAME_LEN_W'(1))) begin
            state_nxt = EMIT;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      EMIT: begin
        if (i_frame_start) begin
          err_nxt = 1'b1;
        end
        if (word_acc) begin
          shreg_nxt = '0;
          idx_nxt   = '0;
          state_nxt = (rem_cnt != '0) ? COLLECT : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      rem_cnt      <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      o_bit_ready  <= 1'b0;
      o_data_valid <= 1'b0;
      o_data_last  <= 1'b0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_nxt;
      rem_cnt      <= rem_nxt;
      bit_idx      <= idx_nxt;
      shreg        <= shreg_nxt;
      o_bit_ready  <= (state_nxt == COLLECT);
      o_data_valid <= (state_nxt == EMIT);
      o_data_last  <= (state_nxt == EMIT) && (rem_nxt == '0);
      o_busy       <= (state_nxt != IDLE);
      o_err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with hand-computed expected words.
module tb_sipo_frame_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_frame_start;
  logic [11:0] i_frame_len;
  logic        i_bit;
  logic        i_bit_valid;
  logic        o_bit_ready;
  logic [7:0]  o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic        o_data_last;
  logic        o_busy;
  logic        o_err;

  int vectors;
  int miscompares;

  sipo_frame_ctrl #(
    .DATA_OUT_W (8),
    .FRAME_LEN_W(12)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_frame_start(i_frame_start),
    .i_frame_len  (i_frame_len),
    .i_bit        (i_bit),
    .i_bit_valid  (i_bit_valid),
    .o_bit_ready  (o_bit_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .o_data_last  (o_data_last),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [11:0] len);
    i_frame_start = 1'b1;
    i_frame_len   = len;
    tick();
    i_frame_start = 1'b0;
  endtask

  // Push n bits (LSB of bits first), check the emitted word, then accept it
  task automatic word(input string tag, input logic [31:0] bits, input int n,
                      input logic [7:0] exp_data, input logic exp_last);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_rdy"}, 32'(o_bit_ready), 32'(1'b1));
      i_bit       = bits[i];
      i_bit_valid = 1'b1;
      tick();
      if (i == n - 2) chk({tag, "_lat"}, 32'(o_data_valid), 32'(1'b0));
    end
    i_bit_valid = 1'b0;
    chk({tag, "_vld"}, 32'(o_data_valid), 32'(1'b1));
    chk({tag, "_nrdy"}, 32'(o_bit_ready), 32'(1'b0));
    chk({tag, "_data"}, 32'(o_data), 32'(exp_data));
    chk({tag, "_last"}, 32'(o_data_last), 32'(exp_last));
    i_data_ready = 1'b1;
    tick();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    i_rst_n       = 1'b0;
    i_frame_start = 1'b0;
    i_frame_len   = '0;
    i_bit         = 1'b0;
    i_bit_valid   = 1'b0;
    i_data_ready  = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(o_busy), 32'(1'b0));
    chk("rst_rdy", 32'(o_bit_ready), 32'(1'b0));
    chk("rst_vld", 32'(o_data_valid), 32'(1'b0));
    chk("rst_data", 32'(o_data), 32'(8'h00));
    chk("rst_err", 32'(o_err), 32'(1'b0));
    i_rst_n = 1'b1;
    tick();

    // T1: 1,0,1,1,0,0,1,0 -> 0x4D last
    start(12'd8);
    chk("t1_busy", 32'(o_busy), 32'(1'b1));
    word("t1", 32'b0100_1101, 8, 8'h4D, 1'b1);
    chk("t1_idle", 32'(o_busy), 32'(1'b0));
    chk("t1_vld0", 32'(o_data_valid), 32'(1'b0));

    // T2: 12 ones -> 0xFF then 0x0F last
    start(12'd12);
    word("t2a", 32'hFFF, 8, 8'hFF, 1'b0);
    chk("t2_busy", 32'(o_busy), 32'(1'b1));
    word("t2b", 32'hFFF, 4, 8'h0F, 1'b1);
    chk("t2_idle", 32'(o_busy), 32'(1'b0));

    // T3: backpressure 5 cycles with bits offered, accept in cycle 6
    start(12'd8);
    i_data_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_bit       = (8'hA5 >> i) & 1'b1;
      i_bit_valid = 1'b1;
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_vld", 32'(o_data_valid), 32'(1'b1));
      chk("t3_hold_data", 32'(o_data), 32'(8'hA5));
      chk("t3_hold_nrdy", 32'(o_bit_ready), 32'(1'b0));
      tick();
    end
    i_bit_valid  = 1'b0;
    i_data_ready = 1'b1;
    chk("t3_c6_data", 32'(o_data), 32'(8'hA5));
    chk("t3_c6_last", 32'(o_data_last), 32'(1'b1));
    tick();
    chk("t3_idle", 32'(o_busy), 32'(1'b0));
    chk("t3_noerr", 32'(o_err), 32'(1'b0));

    // T4: start while busy, zero length, bit in idle
    start(12'd16);
    start(12'd5);
    chk("t4_busy_err", 32'(o_err), 32'(1'b1));
    chk("t4_busy_st", 32'(o_busy), 32'(1'b1));
    tick();
    chk("t4_busy_err0", 32'(o_err), 32'(1'b0));
    word("t4a", 32'h0000, 8, 8'h00, 1'b0);
    word("t4b", 32'h00C3, 8, 8'hC3, 1'b1);
    chk("t4_idle", 32'(o_busy), 32'(1'b0));
    start(12'd0);
    chk("t4_len0_err", 32'(o_err), 32'(1'b1));
    chk("t4_len0_busy", 32'(o_busy), 32'(1'b0));
    tick();
    chk("t4_len0_err0", 32'(o_err), 32'(1'b0));
    i_bit       = 1'b1;
    i_bit_valid = 1'b1;
    tick();
    i_bit_valid = 1'b0;
    chk("t4_idlebit_err", 32'(o_err), 32'(1'b1));
    chk("t4_idlebit_busy", 32'(o_busy), 32'(1'b0));
    tick();
    chk("t4_idlebit_err0", 32'(o_err), 32'(1'b0));

    // T5: reset after 10 bits of a 20-bit frame
    start(12'd20);
    word("t5a", 32'h00FF, 8, 8'hFF, 1'b0);
    i_bit       = 1'b1;
    i_bit_valid = 1'b1;
    tick();
    tick();
    i_bit_valid = 1'b0;
    i_rst_n     = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(o_busy), 32'(1'b0));
    chk("t5_rst_rdy", 32'(o_bit_ready), 32'(1'b0));
    chk("t5_rst_data", 32'(o_data), 32'(8'h00));
    chk("t5_rst_vld", 32'(o_data_valid), 32'(1'b0));
    chk("t5_rst_last", 32'(o_data_last), 32'(1'b0));
    chk("t5_rst_err", 32'(o_err), 32'(1'b0));
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("t5_post_vld", 32'(o_data_valid), 32'(1'b0));
    start(12'd3);
    word("t5b", 32'b011, 3, 8'h03, 1'b1);

    // T6: single-bit frame, then an immediate new frame
    start(12'd1);
    word("t6a", 32'b1, 1, 8'h01, 1'b1);
    start(12'd2);
    chk("t6_restart_err", 32'(o_err), 32'(1'b0));
    chk("t6_restart_busy", 32'(o_busy), 32'(1'b1));
    // frame_start coincident with the final acceptance is rejected
    i_bit_valid = 1'b1;
    i_bit       = 1'b0;
    tick();
    i_bit = 1'b1;
    tick();
    i_bit_valid = 1'b0;
    chk("t6b_data", 32'(o_data), 32'(8'h02));
    chk("t6b_last", 32'(o_data_last), 32'(1'b1));
    i_frame_start = 1'b1;
    i_frame_len   = 12'd4;
    tick();
    i_frame_start = 1'b0;
    chk("t6_coinc_err", 32'(o_err), 32'(1'b1));
    chk("t6_coinc_busy", 32'(o_busy), 32'(1'b0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
